// File: rtl/logic_event_pkg.sv
// Shared types and defaults for the logic event monitor.
package logic_event_pkg;

  // Debounce FSM states; bit 1 doubles as the accepted (filtered) level.
  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_CHK_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_CHK_L = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_CNT_WIDTH   = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser bringing a single asynchronous bit into the clk domain.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_sync
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_in};
  end

  assign d_sync = sync_q[STAGES-1];

endmodule

// File: rtl/logic_event_monitor.sv
// Synchronises and debounces the upstream logic output, emits edge pulses
// and counts accepted rising events in a saturating counter.
module logic_event_monitor
  import logic_event_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 y_in,
  input  logic                 en,
  input  logic                 clr,
  output logic                 y_filt,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] evt_cnt,
  output logic                 cnt_sat
);

  // Smallest counter that can hold DEB_CYCLES-1 (DEB_CYCLES >= 2 keeps this >= 1).
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0]        DCNT_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic          s;
  deb_state_t    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rise_d, fall_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (y_in),
    .d_sync (s)
  );

  // Next-state logic: a candidate level must be seen DEB_CYCLES times in a
  // row; any disagreeing sample drops back to the current accepted level.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_CHK_H;
          dcnt_d  = DW'(1);
        end
      end
      ST_CHK_H: begin
        if (!s) begin
          state_d = ST_LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_HIGH;
          dcnt_d  = '0;
          rise_d  = 1'b1;
        end else begin
          dcnt_d  = dcnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_CHK_L;
          dcnt_d  = DW'(1);
        end
      end
      ST_CHK_L: begin
        if (s) begin
          state_d = ST_HIGH;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_LOW;
          dcnt_d  = '0;
          fall_d  = 1'b1;
        end else begin
          dcnt_d  = dcnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, debounce count and edge pulses; pulses land with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOW;
      dcnt_q     <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  // Accepted level is high in ST_HIGH and while checking a possible fall.
  assign y_filt = state_q[1];

  // Saturating event counter fed by the registered rise pulse; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (clr) begin
      evt_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (en && rise_pulse && (evt_cnt != CNT_MAX)) begin
      evt_cnt <= evt_cnt + 1'b1;
      cnt_sat <= (evt_cnt == (CNT_MAX - 1'b1));
    end
  end

endmodule
